wb_trace_tx: RTL and testbench

Register-writeback trace transmitter for the darksocv core. It captures every architectural register write (destination pointer plus value) in a small FIFO and streams each event as a fixed-length byte record over a valid/ready link. An external observer, either a bench monitor or a debug UART bridge, can reconstruct the register file from this stream without probing core internals. It sits beside the core, fed from the writeback stage.

---
 rtl/wb_trace_tx.sv | 178 +++++++++++++++++
 tb/tb_wb_trace_tx.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_trace_tx.sv
// -----------------------------------------------------------------------------
// wb_trace_tx
// Register-writeback trace transmitter. Every architectural register write
// (destination index plus value) is captured into a small FIFO and streamed
// as a fixed-length byte record over a valid/ready link. An observer can
// rebuild the register file from the stream alone.
//
// Record layout, in transmit order:
//   byte0    = {ovf, 2'b00, DPTR[4:0]}   ovf=1: events were lost before this one
//   byte1..4 = RMDATA[7:0] .. RMDATA[31:24]
//   byte5..6 = ts[7:0], ts[15:8]         only when TRACE_TS_EN is defined
//
// Build option: define TRACE_TS_EN to add a 16-bit free-running cycle
// timestamp to each record (7-byte records instead of 5).
//
// Ports:
//   CLK       core clock, all state on rising edge
//   RES       asynchronous active-high reset
//   HLT       core halt, suppresses capture
//   WB_EN     writeback strobe, one cycle per register write
//   DPTR      destination register index (x0 writes are never traced)
//   RMDATA    value written to DPTR
//   TX_DATA   current record byte (0 while TX_VALID is low)
//   TX_VALID  TX_DATA valid
//   TX_READY  sink accepts the byte this cycle
//   LEVEL     FIFO occupancy
//   DROP_CNT  saturating count of events lost to a full FIFO
// -----------------------------------------------------------------------------
module wb_trace_tx #(
    parameter int DEPTH = 8,
    parameter int OVF_W = 8
) (
    input  logic                     CLK,
    input  logic                     RES,
    input  logic                     HLT,
    input  logic                     WB_EN,
    input  logic [4:0]               DPTR,
    input  logic [31:0]              RMDATA,
    output logic [7:0]               TX_DATA,
    output logic                     TX_VALID,
    input  logic                     TX_READY,
    output logic [$clog2(DEPTH):0]   LEVEL,
    output logic [OVF_W-1:0]         DROP_CNT
);

    localparam int AW = $clog2(DEPTH);

`ifdef TRACE_TS_EN
    localparam int NB = 7;
`else
    localparam int NB = 5;
`endif
    localparam logic [2:0] LAST  = 3'(NB - 1);
    // Stored entry drops the two constant zero bits of byte0.
    localparam int         ENT_W = NB * 8 - 2;

    typedef enum logic {S_IDLE, S_SEND} state_t;

    logic [ENT_W-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr, r_rd_ptr;
    logic             r_sticky;
    logic [OVF_W-1:0] r_drop;
    state_t           r_state;
    state_t           w_state_nxt;
    logic [2:0]       r_idx;
    logic [NB*8-1:0]  r_shift;

    logic             w_evt, w_push, w_pop, w_shift;
    logic             w_empty, w_full;
    logic [ENT_W-1:0] w_entry_in, w_head;
    logic [NB*8-1:0]  w_rec;

    // ------------------------------------------------------------------
    // Capture side
    // ------------------------------------------------------------------
`ifdef TRACE_TS_EN
    logic [15:0] r_ts;

    always_ff @(posedge CLK or posedge RES) begin
        if (RES) r_ts <= '0;
        else     r_ts <= r_ts + 16'd1;
    end

    assign w_entry_in = {r_ts, RMDATA, r_sticky, DPTR};
`else
    assign w_entry_in = {RMDATA, r_sticky, DPTR};
`endif

    assign w_evt   = WB_EN && !HLT && (DPTR != 5'd0);
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    // A full FIFO still takes the event when the head leaves on the same edge;
    // both pointers then address the same slot, read before it is overwritten.
    assign w_push  = w_evt && (!w_full || w_pop);

    assign LEVEL    = r_wr_ptr - r_rd_ptr;
    assign DROP_CNT = r_drop;

    // NOTE: storage has no reset; the pointers alone define which slots are valid.
    always_ff @(posedge CLK) begin
        if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= w_entry_in;
    end

    // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLK or posedge RES) begin
        if (RES) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_sticky <= 1'b0;
            r_drop   <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
            // Sticky flag rides on the next accepted entry, then clears.
            if (w_push) begin
                r_sticky <= 1'b0;
            end else if (w_evt) begin
                r_sticky <= 1'b1;
                if (r_drop != {OVF_W{1'b1}}) r_drop <= r_drop + OVF_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Serializer
    // ------------------------------------------------------------------
    assign w_head = r_mem[r_rd_ptr[AW-1:0]];
    assign w_rec  = {w_head[ENT_W-1:6], w_head[5], 2'b00, w_head[4:0]};

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_shift     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_state_nxt = S_SEND;
                end
            end
            S_SEND: begin
                if (TX_READY) begin
                    if (r_idx == LAST) begin
                        // Chain straight into the next record when one is waiting.
                        if (!w_empty) w_pop = 1'b1;
                        else          w_state_nxt = S_IDLE;
                    end else begin
                        w_shift = 1'b1;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RES) begin
        if (RES) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
            r_shift <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_pop) begin
                r_shift <= w_rec;
                r_idx   <= '0;
            end else if (w_shift) begin
                r_shift <= r_shift >> 8;
                r_idx   <= r_idx + 3'd1;
            end
        end
    end

    assign TX_VALID = (r_state == S_SEND);
    assign TX_DATA  = TX_VALID ? r_shift[7:0] : 8'h00;

endmodule

// File: tb/tb_wb_trace_tx.sv
// -----------------------------------------------------------------------------
// tb_wb_trace_tx
// Self-checking bench for wb_trace_tx. A behavioural model follows the link
// at record level (pending-record count, bytes left in the current record)
// and pushes each accepted event's bytes into an expected-byte queue; a
// monitor on the falling edge pops and compares whenever TX_VALID is high.
// -----------------------------------------------------------------------------
module tb_wb_trace_tx;

    localparam int DEPTH = 8;
    localparam int OVF_W = 8;
`ifdef TRACE_TS_EN
    localparam int NB = 7;
`else
    localparam int NB = 5;
`endif

    logic        CLK = 1'b0;
    logic        RES = 1'b1;
    logic        HLT = 1'b0;
    logic        WB_EN = 1'b0;
    logic [4:0]  DPTR = '0;
    logic [31:0] RMDATA = '0;
    logic        TX_READY = 1'b0;
    logic [7:0]  TX_DATA;
    logic        TX_VALID;
    logic [$clog2(DEPTH):0] LEVEL;
    logic [OVF_W-1:0]       DROP_CNT;

    wb_trace_tx #(.DEPTH(DEPTH), .OVF_W(OVF_W)) dut (
        .CLK(CLK), .RES(RES), .HLT(HLT), .WB_EN(WB_EN), .DPTR(DPTR),
        .RMDATA(RMDATA), .TX_DATA(TX_DATA), .TX_VALID(TX_VALID),
        .TX_READY(TX_READY), .LEVEL(LEVEL), .DROP_CNT(DROP_CNT)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h expected=0x%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: records waiting, bytes left in the one on the wire.
    // ------------------------------------------------------------------
    logic [7:0]  exp_q[$];
    int          m_pend = 0;
    int          m_rem = 0;
    bit          m_busy = 1'b0;
    bit          m_sticky = 1'b0;
    int          m_drop = 0;
    logic [15:0] m_ts = '0;

    always @(posedge CLK or posedge RES) begin
        bit evt, pop, acc;
        if (RES) begin
            exp_q.delete();
            m_pend = 0; m_rem = 0; m_busy = 1'b0;
            m_sticky = 1'b0; m_drop = 0; m_ts = '0;
        end else begin
            evt = WB_EN && !HLT && (DPTR != 5'd0);
            pop = (m_pend > 0) && (!m_busy || (TX_READY && m_rem == 1));
            acc = evt && (m_pend < DEPTH || pop);
            if (m_busy && TX_READY) m_rem--;
            if (pop) begin
                m_pend--;
                m_busy = 1'b1;
                m_rem  = NB;
            end else if (m_busy && m_rem == 0) begin
                m_busy = 1'b0;
            end
            if (acc) begin
                exp_q.push_back({m_sticky, 2'b00, DPTR});
                for (int b = 0; b < 4; b++) exp_q.push_back(8'((RMDATA >> (8 * b)) & 32'hFF));
`ifdef TRACE_TS_EN
                exp_q.push_back(m_ts[7:0]);
                exp_q.push_back(m_ts[15:8]);
`endif
                m_pend++;
                m_sticky = 1'b0;
            end else if (evt) begin
                m_sticky = 1'b1;
                if (m_drop < (1 << OVF_W) - 1) m_drop++;
            end
            m_ts = m_ts + 16'd1;
        end
    end

    // ------------------------------------------------------------------
    // Monitor
    // ------------------------------------------------------------------
    always @(negedge CLK) begin
        check("tx_valid", 32'(TX_VALID), 32'(m_busy));
        check("level", 32'(LEVEL), 32'(m_pend));
        check("drop_cnt", 32'(DROP_CNT), 32'(m_drop));
        if (TX_VALID) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL tx_unexpected_byte actual=0x%02h expected=none t=%0t", TX_DATA, $time);
            end else begin
                check("tx_data", 32'(TX_DATA), 32'(exp_q[0]));
                if (TX_READY) void'(exp_q.pop_front());
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic ev(input logic [4:0] d, input logic [31:0] v);
        WB_EN = 1'b1; DPTR = d; RMDATA = v;
        cyc();
        WB_EN = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        WB_EN = 1'b0; HLT = 1'b0; TX_READY = 1'b1;
        while ((exp_q.size() != 0 || m_busy) && n < 2000) begin
            cyc();
            n++;
        end
        check("drain_done", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (3) cyc();
        check("rst_valid", 32'(TX_VALID), 32'd0);
        check("rst_data", 32'(TX_DATA), 32'd0);
        check("rst_level", 32'(LEVEL), 32'd0);
        check("rst_drop", 32'(DROP_CNT), 32'd0);
        RES = 1'b0;
        cyc();

        // Single event: fixed stream and one-cycle latency to TX_VALID
        TX_READY = 1'b1;
        ev(5'd5, 32'hDEADBEEF);
        check("lat_edge_k", 32'(TX_VALID), 32'd0);
        cyc();
        check("lat_edge_k1", 32'(TX_VALID), 32'd1);
        check("single_b0", 32'(TX_DATA), 32'h05);
        cyc(); check("single_b1", 32'(TX_DATA), 32'hEF);
        cyc(); check("single_b2", 32'(TX_DATA), 32'hBE);
        cyc(); check("single_b3", 32'(TX_DATA), 32'hAD);
        cyc(); check("single_b4", 32'(TX_DATA), 32'hDE);
        drain();

        // Filtering: x0 and halted writes are never traced
        WB_EN = 1'b1; DPTR = 5'd0; RMDATA = $urandom; cyc();
        HLT = 1'b1; DPTR = 5'd3; RMDATA = $urandom; cyc();
        WB_EN = 1'b0; HLT = 1'b0; cyc(); cyc();
        check("filter_level", 32'(LEVEL), 32'd0);
        check("filter_valid", 32'(TX_VALID), 32'd0);

        // Backpressure: TX_READY toggles every cycle during a record
        TX_READY = 1'b0;
        ev(5'd7, $urandom);
        for (int i = 0; i < 2 * NB + 4; i++) begin
            TX_READY = ~TX_READY;
            cyc();
        end
        drain();

        // Overflow: one record stalled on the wire, then DEPTH+3 writes
        TX_READY = 1'b0;
        ev(5'd1, $urandom);
        cyc();
        for (int i = 0; i < DEPTH + 3; i++) ev(5'(i % 31 + 2), $urandom);
        cyc();
        check("ovf_level", 32'(LEVEL), DEPTH);
        check("ovf_drop", 32'(DROP_CNT), 32'd3);
        drain();
        ev(5'd12, $urandom);
        ev(5'd13, $urandom);
        drain();

        // Full FIFO with a pop on the same edge as a new event
        TX_READY = 1'b0;
        ev(5'd20, $urandom);
        cyc();
        for (int i = 0; i < DEPTH; i++) ev(5'(i + 21), $urandom);
        check("full_level", 32'(LEVEL), DEPTH);
        TX_READY = 1'b1;
        repeat (NB - 1) cyc();
        ev(5'd31, $urandom);
        check("full_pop_drop", 32'(DROP_CNT), 32'd3);
        check("full_pop_level", 32'(LEVEL), DEPTH);
        drain();

        // Reset mid-record with 3 entries queued
        TX_READY = 1'b0;
        ev(5'd9, $urandom);
        cyc();
        for (int i = 0; i < 3; i++) ev(5'(i + 10), $urandom);
        TX_READY = 1'b1;
        repeat (3) cyc();
        TX_READY = 1'b0;
        #2;
        RES = 1'b1;
        #1;
        check("midrst_valid", 32'(TX_VALID), 32'd0);
        check("midrst_level", 32'(LEVEL), 32'd0);
        cyc(); cyc();
        RES = 1'b0;
        TX_READY = 1'b1;
        repeat (20) cyc();
        ev(5'd4, $urandom);
        drain();

        // Randomized traffic with random backpressure
        for (int i = 0; i < 600; i++) begin
            WB_EN    = ($urandom_range(0, 99) < 60);
            HLT      = ($urandom_range(0, 99) < 10);
            DPTR     = 5'($urandom_range(0, 31));
            RMDATA   = $urandom;
            TX_READY = ($urandom_range(0, 99) < 50);
            cyc();
        end
        drain();
        cyc();
        check("end_valid", 32'(TX_VALID), 32'd0);
        check("end_level", 32'(LEVEL), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
